// File: rtl/io_request_server.sv
// io_request_server: UART byte <-> 32-bit word responder with RX/TX FIFOs; define IO_ERR_STATUS_EN for sticky overflow flags.
module io_request_server #(
    parameter int RECV_DEPTH = 256,
    parameter int SEND_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    input  logic                          send_en,
    input  logic [31:0]                   send_content,
    output logic                          send_busy,
    input  logic                          recv_en,
    output logic [31:0]                   recv_rd,
    output logic [$clog2(RECV_DEPTH):0]   recv_size,
    output logic [1:0]                    err_status
);
    localparam int RA = $clog2(RECV_DEPTH);
    localparam int TA = $clog2(SEND_DEPTH);
    localparam logic [RA:0] RFULL = (RA+1)'(RECV_DEPTH);
    localparam logic [TA:0] TFULL = (TA+1)'(SEND_DEPTH);
    localparam logic [TA:0] TLIM = (TA+1)'(SEND_DEPTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [1:0]    ridx;
    logic [23:0]   rbuf;
    logic [31:0]   rmem [RECV_DEPTH];
    logic [RA-1:0] rwp, rrp;
    logic [RA:0]   rcnt;
    logic [31:0]   rlast;
    logic          rpush, rpop, racc;
    logic [31:0]   rword;

    logic [31:0]   tmem [SEND_DEPTH];
    logic [TA-1:0] twp, trp;
    logic [TA:0]   tcnt, tcnt_n;
    logic          tpush, tpop;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [31:0]   shift, shift_n;

    // Bytes shift in from the top so the first byte ends up in bits [7:0].
    assign rpush = rx_valid && ridx == 2'd3;
    assign rword = {rx_data, rbuf};
    assign rpop = recv_en && rcnt != '0;
    assign racc = rpush && (rcnt != RFULL || rpop);
    assign recv_rd = rcnt != '0 ? rmem[rrp] : rlast;
    assign recv_size = rcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            ridx <= 2'd0;
            rbuf <= '0;
            rwp <= '0;
            rrp <= '0;
            rcnt <= '0;
            rlast <= '0;
        end else begin
            if (rx_valid) begin
                ridx <= ridx + 2'd1;
                rbuf <= {rx_data, rbuf[23:8]};
            end
            if (racc) rwp <= rwp + 1'b1;
            if (rpop) rrp <= rrp + 1'b1;
            rcnt <= rcnt + {{RA{1'b0}}, racc} - {{RA{1'b0}}, rpop};
            rlast <= recv_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (racc) rmem[rwp] <= rword;
        if (tpush) tmem[twp] <= send_content;
    end

    assign tpush = send_en && (tcnt != TFULL || tpop);
    assign tcnt_n = tcnt + {{TA{1'b0}}, tpush} - {{TA{1'b0}}, tpop};

    always_ff @(posedge clock) begin
        if (reset) begin
            twp <= '0;
            trp <= '0;
            tcnt <= '0;
            send_busy <= 1'b0;
        end else begin
            if (tpush) twp <= twp + 1'b1;
            if (tpop) trp <= trp + 1'b1;
            tcnt <= tcnt_n;
            send_busy <= tcnt_n > TLIM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx <= 2'd0;
            shift <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            shift <= shift_n;
        end
    end

    // Loading the next word on the last byte's handshake keeps words back-to-back.
    always_comb begin
        state_n = state;
        idx_n = idx;
        shift_n = shift;
        tpop = 1'b0;
        if (state == IDLE) begin
            if (tcnt != '0) begin
                tpop = 1'b1;
                shift_n = tmem[trp];
                idx_n = 2'd0;
                state_n = SHIFT;
            end
        end else if (tx_ready) begin
            if (idx != 2'd3) begin
                idx_n = idx + 2'd1;
            end else if (tcnt != '0) begin
                tpop = 1'b1;
                shift_n = tmem[trp];
                idx_n = 2'd0;
            end else begin
                state_n = IDLE;
            end
        end
    end

    assign tx_valid = state == SHIFT;
    assign tx_data = tx_valid ? shift[8*idx +: 8] : 8'd0;

`ifdef IO_ERR_STATUS_EN
    logic [1:0] err;
    always_ff @(posedge clock) begin
        if (reset) err <= 2'b00;
        else err <= err | {send_en && !tpush, rpush && !racc};
    end
    assign err_status = err;
`else
    assign err_status = 2'b00;
`endif
endmodule

// File: tb/tb_io_request_server.sv
// tb_io_request_server: directed vector table plus hand sequences for FIFO limits and reset.
module tb_io_request_server;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        send_en = 1'b0;
    logic [31:0] send_content = 32'd0;
    logic        send_busy;
    logic        recv_en = 1'b0;
    logic [31:0] recv_rd;
    logic [8:0]  recv_size;
    logic [1:0]  err_status;

    int n_chk = 0;
    int n_fail = 0;

`ifdef IO_ERR_STATUS_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    io_request_server dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .send_en(send_en), .send_content(send_content), .send_busy(send_busy),
        .recv_en(recv_en), .recv_rd(recv_rd), .recv_size(recv_size), .err_status(err_status)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        ren;
        logic        sen;
        logic [31:0] sc;
        logic        trdy;
        logic        ev;
        logic [7:0]  ed;
        logic [8:0]  es;
        logic [31:0] er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rv, input logic [7:0] rd, input logic ren, input logic sen,
                       input logic [31:0] sc, input logic trdy, input logic ev, input logic [7:0] ed,
                       input logic [8:0] es, input logic [31:0] er);
        vec_t v;
        v = '{rv, rd, ren, sen, sc, trdy, ev, ed, es, er};
        vq.push_back(v);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rxw(input logic [31:0] w, input logic pop_last);
        for (int b = 0; b < 4; b++) begin
            rx_valid = 1'b1;
            rx_data = w[8*b +: 8];
            recv_en = (b == 3) && pop_last;
            tick;
        end
        rx_valid = 1'b0;
        recv_en = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        int nb;
        logic [31:0] last;

        // reset state
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(send_busy), 32'd0);
        chk("rst_size", 32'(recv_size), 32'd0);
        chk("rst_rd", recv_rd, 32'd0);
        chk("rst_err", 32'(err_status), 32'd0);

        // RX word, pop, then TX single word, back-to-back words, stalled word
        add(1'b1, 8'h78, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h0);
        add(1'b1, 8'h56, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h0);
        add(1'b1, 8'h34, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h0);
        add(1'b1, 8'h12, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd1, 32'h12345678);
        add(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hEF, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hBE, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hAD, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hDE, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1, 8'h11, 9'd0, 32'h12345678);
        for (int i = 0; i < 3; i++)
            add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h11, 9'd0, 32'h12345678);
        for (int i = 0; i < 4; i++)
            add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 1'b0, 8'h00, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hD4, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hD4, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hC3, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hB2, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hA1, 9'd0, 32'h12345678);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 9'd0, 32'h12345678);

        foreach (vq[i]) begin
            rx_valid = vq[i].rv;
            rx_data = vq[i].rd;
            recv_en = vq[i].ren;
            send_en = vq[i].sen;
            send_content = vq[i].sc;
            tx_ready = vq[i].trdy;
            tick;
            chk($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vq[i].ev));
            if (vq[i].ev) chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vq[i].ed));
            chk($sformatf("vec%0d_size", i), 32'(recv_size), 32'(vq[i].es));
            chk($sformatf("vec%0d_rd", i), recv_rd, vq[i].er);
        end
        rx_valid = 1'b0;
        recv_en = 1'b0;
        send_en = 1'b0;

        // TX FIFO fill: first word parks in the shifter, then 16 fill the FIFO, 17th dropped
        tx_ready = 1'b0;
        send_en = 1'b1;
        send_content = 32'hC0000000;
        tick;
        send_en = 1'b0;
        tick;
        chk("fill_shift_loaded", 32'(tx_valid), 32'd1);
        for (int k = 1; k <= 15; k++) begin
            send_en = 1'b1;
            send_content = 32'(k);
            tick;
            if (k == 14) chk("busy_at_14", 32'(send_busy), 32'd0);
        end
        chk("busy_at_15", 32'(send_busy), 32'd1);
        send_content = 32'd16;
        tick;
        chk("busy_at_16", 32'(send_busy), 32'd1);
        chk("err_send_before", 32'(err_status[1]), 32'd0);
        send_content = 32'd17;
        tick;
        send_en = 1'b0;
        chk("err_send_ovf", 32'(err_status[1]), 32'(ERR_ON));
        tx_ready = 1'b1;
        nb = 0;
        last = 32'd0;
        for (int c = 0; c < 200; c++) begin
            if (tx_valid) begin
                nb++;
                last = {tx_data, last[31:8]};
            end
            tick;
        end
        chk("drain_bytes", 32'(nb), 32'd68);
        chk("drain_last_word", last, 32'd16);
        chk("drain_busy", 32'(send_busy), 32'd0);

        // RX FIFO full: push with pop accepted, push without pop dropped
        do_reset;
        chk("rst2_err", 32'(err_status), 32'd0);
        for (int i = 0; i < 256; i++) rxw(32'(i), 1'b0);
        chk("rx_full_size", 32'(recv_size), 32'd256);
        chk("rx_full_head", recv_rd, 32'd0);
        rxw(32'd256, 1'b1);
        chk("rx_pushpop_size", 32'(recv_size), 32'd256);
        chk("rx_pushpop_head", recv_rd, 32'd1);
        chk("rx_pushpop_err", 32'(err_status[0]), 32'd0);
        rxw(32'h00000BAD, 1'b0);
        chk("rx_drop_size", 32'(recv_size), 32'd256);
        chk("rx_drop_err", 32'(err_status[0]), 32'(ERR_ON));
        for (int i = 1; i <= 256; i++) begin
            chk($sformatf("rx_pop%0d", i), recv_rd, 32'(i));
            recv_en = 1'b1;
            tick;
        end
        chk("rx_empty_size", 32'(recv_size), 32'd0);
        tick;
        chk("rx_underflow_size", 32'(recv_size), 32'd0);
        recv_en = 1'b0;

        // reset discards a partial word and a word in flight
        tx_ready = 1'b0;
        send_en = 1'b1;
        send_content = 32'h55AA55AA;
        tick;
        send_en = 1'b0;
        tick;
        chk("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        tick;
        rx_data = 8'hBB;
        tick;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tx_ready = 1'b0;
        chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("post_rst_size", 32'(recv_size), 32'd0);
        chk("post_rst_err", 32'(err_status), 32'd0);
        rxw(32'h04030201, 1'b0);
        chk("post_rst_word_size", 32'(recv_size), 32'd1);
        chk("post_rst_word", recv_rd, 32'h04030201);
        tick;
        chk("post_rst_tx_idle", 32'(tx_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
